// File: rtl/fifo.sv
// Single-clock byte FIFO with registered read data, occupancy status flags
// and one-cycle overflow/underflow error pulses.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_wr_en      push i_data_in this edge
//   i_rd_en      pop the oldest word this edge
//   i_data_in    write data
//   o_data_out   registered read data (valid the cycle after an accepted read)
//   o_full       occupancy == DEPTH
//   o_empty      occupancy == 0
//   o_overflow   one-cycle pulse: a write was rejected
//   o_underflow  one-cycle pulse: a read was rejected
//   o_threshold  occupancy >= THRESHOLD
module fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned THRESHOLD  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_threshold
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;

  // Status decode from the registered count.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));

  // A read frees a slot on the same edge, so a write at full is accepted
  // alongside it; a read at empty never sees the concurrent write.
  assign w_rd_acc = i_rd_en && !w_empty;
  assign w_wr_acc = i_wr_en && (!w_full || w_rd_acc);

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // Pointers, count, read data and error pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= i_wr_en && !w_wr_acc;
      r_underflow <= i_rd_en && !w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data_out  = r_data_out;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_threshold = (r_count >= CW'(THRESHOLD));

endmodule

// File: tb/tb_fifo.sv
// Testbench for fifo: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_fifo;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned THRESHOLD = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
  logic       threshold;

  int errors = 0;
  int checks = 0;

  fifo dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_wr_en     (wr_en),
    .i_rd_en     (rd_en),
    .i_data_in   (data_in),
    .o_data_out  (data_out),
    .o_full      (full),
    .o_empty     (empty),
    .o_overflow  (overflow),
    .o_underflow (underflow),
    .o_threshold (threshold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO as a bounded queue.
  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  logic       m_ov;
  logic       m_un;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_dout  = 8'h00;
      m_ov    = 1'b0;
      m_un    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit rd_ok;
      bit wr_ok;
      rd_ok = rd_en && (m_q.size() > 0);
      wr_ok = wr_en && ((m_q.size() < DEPTH) || rd_ok);
      m_ov  = wr_en && !wr_ok;
      m_un  = rd_en && !rd_ok;
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(data_in);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_data_out",  data_out,        m_dout);
      chk("cmp_full",      8'(full),        8'(m_q.size() == DEPTH));
      chk("cmp_empty",     8'(empty),       8'(m_q.size() == 0));
      chk("cmp_threshold", 8'(threshold),   8'(m_q.size() >= THRESHOLD));
      chk("cmp_overflow",  8'(overflow),    8'(m_ov));
      chk("cmp_underflow", 8'(underflow),   8'(m_un));
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [7:0] d);
    @(negedge clk);
    reset   = rst;
    wr_en   = wr;
    rd_en   = rd;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq5 [5];

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    seq5[0] = 8'hA1; seq5[1] = 8'hB2; seq5[2] = 8'hC3; seq5[3] = 8'hD4; seq5[4] = 8'hE5;

    // Reset state
    step(1, 0, 0, 8'h00);
    chk("rst_empty", 8'(empty), 8'h01);
    chk("rst_full",  8'(full), 8'h00);
    chk("rst_thr",   8'(threshold), 8'h00);
    chk("rst_dout",  data_out, 8'h00);

    // Five writes; threshold asserts at occupancy 4
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, seq5[i]);
      if (i == 2) chk("thr_at3", 8'(threshold), 8'h00);
      if (i == 3) chk("thr_at4", 8'(threshold), 8'h01);
    end
    chk("w5_thr",   8'(threshold), 8'h01);
    chk("w5_empty", 8'(empty), 8'h00);
    chk("w5_full",  8'(full), 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8'h00);
      chk("r5_dout", data_out, seq5[i]);
    end
    chk("r5_empty", 8'(empty), 8'h01);
    chk("r5_thr",   8'(threshold), 8'h00);

    // Alternating write/read
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'(8'h10 + i));
      chk("alt_empty_w", 8'(empty), 8'h00);
      step(0, 0, 1, 8'h00);
      chk("alt_dout", data_out, 8'(8'h10 + i));
      chk("alt_empty_r", 8'(empty), 8'h01);
      chk("alt_err", 8'({overflow, underflow}), 8'h00);
    end

    // Fill, overflow attempt, then simultaneous read/write at full
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'(i));
      if (i == 6) chk("fill7_full", 8'(full), 8'h00);
    end
    chk("fill8_full", 8'(full), 8'h01);
    step(0, 1, 0, 8'hFF);
    chk("ovf_pulse", 8'(overflow), 8'h01);
    chk("ovf_full",  8'(full), 8'h01);
    step(0, 0, 0, 8'h00);
    chk("ovf_clear", 8'(overflow), 8'h00);
    step(0, 1, 1, 8'h99);
    chk("rw_full_dout", data_out, 8'h00);
    chk("rw_full_full", 8'(full), 8'h01);
    chk("rw_full_ovf",  8'(overflow), 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 8'h00);
      chk("drain_dout", data_out, (i == 8) ? 8'h99 : 8'(i));
    end
    chk("drain_empty", 8'(empty), 8'h01);

    // Underflow, alone and with a concurrent write
    step(0, 0, 1, 8'h00);
    chk("unf_pulse", 8'(underflow), 8'h01);
    chk("unf_dout",  data_out, 8'h99);
    step(0, 0, 0, 8'h00);
    chk("unf_clear", 8'(underflow), 8'h00);
    step(0, 1, 1, 8'h5A);
    chk("unf_rw_pulse", 8'(underflow), 8'h01);
    chk("unf_rw_empty", 8'(empty), 8'h00);
    step(0, 0, 1, 8'h00);
    chk("unf_rw_dout", data_out, 8'h5A);

    // Reset mid-fill, with a write in flight
    step(0, 1, 0, 8'h31);
    step(0, 1, 0, 8'h32);
    step(0, 1, 0, 8'h33);
    step(1, 1, 1, 8'h34);
    chk("mrst_empty", 8'(empty), 8'h01);
    chk("mrst_dout",  data_out, 8'h00);
    chk("mrst_flags", 8'({full, overflow, underflow, threshold}), 8'h00);
    step(0, 0, 1, 8'h00);
    chk("mrst_unf",   8'(underflow), 8'h01);
    chk("mrst_dout2", data_out, 8'h00);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      int unsigned wbias;
      wbias = (n / 300) % 3;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 3 + 2 * wbias),
           ($urandom_range(0, 9) < 7 - 2 * wbias),
           8'($urandom));
    end
    step(0, 0, 0, 8'h00);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
